quan_bias_set_feeder: RTL and testbench

Sequencer that drives the `next_bias_set` input of the bias-add vector stage. It reads 8-bit signed biases from the on-chip bias buffer over a synchronous read port and packs them into a 16-bit bias set: one channel for mode 0 (8x8) or two channels for mode 1 (1x8). It holds each set for a programmed number of vector operations, then advances to the next output-channel group. It sits between the bias buffer and the quantisation vector pipeline, and is started once per layer tile by the layer controller.

---
 rtl/quan_bias_set_feeder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_quan_bias_set_feeder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/quan_bias_set_feeder.sv
// quan_bias_set_feeder: fetches 8-bit biases from the bias buffer and presents
// them as 16-bit bias sets to the bias-add vector stage. Each set holds one
// channel (mode 0) or two channels (mode 1) and is kept for tiles_per_set
// vector ops. Optional build macro QUAN_BIAS_PREFETCH_EN adds a shadow set
// register that is filled while the current set is presented, hiding the
// refetch bubble.
module quan_bias_set_feeder #(
  parameter int bias_width            = 8,
  parameter int pe_parallel_weight_18 = 2,
  parameter int bias_set_width        = bias_width*pe_parallel_weight_18,
  parameter int bias_addr_width       = 10,
  parameter int och_width             = 10,
  parameter int tile_cnt_width        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 mode,
  input  logic                       start,
  input  logic [bias_addr_width-1:0] base_addr,
  input  logic [och_width-1:0]       och_num,
  input  logic [tile_cnt_width-1:0]  tiles_per_set,
  output logic                       bias_rd_en,
  output logic [bias_addr_width-1:0] bias_rd_addr,
  input  logic [bias_width-1:0]      bias_rd_data,
  input  logic                       vec_en,
  output logic [bias_set_width-1:0]  next_bias_set,
  output logic                       bias_valid,
  output logic                       busy,
  output logic                       done
);

  // one extra bit so c+2 past the last channel cannot wrap
  localparam int CW = och_width + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH_LO = 3'd1;
  localparam logic [2:0] ST_FETCH_HI = 3'd2;
  localparam logic [2:0] ST_PRESENT  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [CW-1:0]              CH_ONE    = 1;
  localparam logic [CW-1:0]              CH_TWO    = 2;
  localparam logic [och_width-1:0]       OCH_ONE   = 1;
  localparam logic [tile_cnt_width-1:0]  TILE_ONE  = 1;
  localparam logic [bias_addr_width-1:0] ADDR_ONE  = 1;

  logic [2:0]                 state_q, state_d;
  logic                       mode1_q, mode1_d;
  logic [bias_addr_width-1:0] base_q, base_d;
  logic [CW-1:0]              och_q, och_d;
  logic [tile_cnt_width-1:0]  tps_q, tps_d;
  logic [tile_cnt_width-1:0]  tile_cnt_q, tile_cnt_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic                       rd_en_q, rd_en_d;
  logic [bias_addr_width-1:0] rd_addr_q, rd_addr_d;
  logic                       rd_hi_q, rd_hi_d;
  logic                       rd_last_q, rd_last_d;
  logic                       hi_pend_q, hi_pend_d;
  logic                       rsp_vld_q, rsp_hi_q, rsp_last_q;
  logic [bias_width-1:0]      lo_byte_q, lo_byte_d;
  logic [bias_set_width-1:0]  set_q, set_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
`ifdef QUAN_BIAS_PREFETCH_EN
  logic [bias_set_width-1:0]  shadow_q, shadow_d;
  logic                       shadow_vld_q, shadow_vld_d;
  logic                       pf_busy_q, pf_busy_d;
`endif

  logic [CW-1:0]              nxt_ch;
  logic                       vec_ok, vec_fin, asm_done;
  logic [bias_set_width-1:0]  asm_set;
  logic                       kick, kick_pair;
  logic [CW-1:0]              kick_ch;
  logic [bias_addr_width-1:0] kick_base;

  // datapath helpers: next channel, final-op detect, set assembly from returning reads
  always_comb begin
    nxt_ch    = ch_q + (mode1_q ? CH_TWO : CH_ONE);
    vec_ok    = vec_en & valid_q;
    vec_fin   = vec_ok && (tile_cnt_q == tps_q - TILE_ONE);
    asm_done  = rsp_vld_q & rsp_last_q;
    asm_set   = rsp_hi_q ? {bias_rd_data, lo_byte_q} : {{bias_width{1'b0}}, bias_rd_data};
    lo_byte_d = (rsp_vld_q && !rsp_last_q) ? bias_rd_data : lo_byte_q;
  end

  // main sequencer: run setup, fetch wait, set presentation and advance
  always_comb begin
    state_d    = state_q;
    mode1_d    = mode1_q;
    base_d     = base_q;
    och_d      = och_q;
    tps_d      = tps_q;
    tile_cnt_d = tile_cnt_q;
    ch_d       = ch_q;
    set_d      = set_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    kick       = 1'b0;
    kick_ch    = nxt_ch;
    kick_base  = base_q;
    kick_pair  = mode1_q && ((nxt_ch + CH_ONE) < och_q);
`ifdef QUAN_BIAS_PREFETCH_EN
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    pf_busy_d    = pf_busy_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode1_d    = (mode == 4'd1);
          base_d     = base_addr;
          och_d      = {1'b0, och_num};
          tps_d      = (tiles_per_set == '0) ? TILE_ONE : tiles_per_set;
          ch_d       = '0;
          tile_cnt_d = '0;
          busy_d     = 1'b1;
          if (och_num == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FETCH_LO;
            kick      = 1'b1;
            kick_ch   = '0;
            kick_base = base_addr;
            kick_pair = (mode == 4'd1) && (och_num > OCH_ONE);
          end
        end
      end
      ST_FETCH_LO, ST_FETCH_HI: begin
        if (asm_done) begin
          set_d   = asm_set;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else if (state_q == ST_FETCH_LO && rd_en_q && rd_hi_q) begin
          state_d = ST_FETCH_HI;
        end
      end
      ST_PRESENT: begin
        if (vec_ok) tile_cnt_d = tile_cnt_q + TILE_ONE;
        if (vec_fin) begin
          tile_cnt_d = '0;
          ch_d       = nxt_ch;
          if (nxt_ch >= och_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end
`ifdef QUAN_BIAS_PREFETCH_EN
          else if (shadow_vld_q) begin
            set_d        = shadow_q;
            shadow_vld_d = 1'b0;
          end else if (pf_busy_q && asm_done) begin
            set_d     = asm_set;
            pf_busy_d = 1'b0;
          end else begin
            // shadow not ready: wait out the rest of the in-flight fetch
            valid_d   = 1'b0;
            state_d   = ST_FETCH_LO;
            pf_busy_d = 1'b0;
            kick      = !pf_busy_q;
          end
`else
          else begin
            valid_d = 1'b0;
            state_d = ST_FETCH_LO;
            kick    = 1'b1;
          end
`endif
        end
`ifdef QUAN_BIAS_PREFETCH_EN
        else begin
          if (pf_busy_q && asm_done) begin
            shadow_d     = asm_set;
            shadow_vld_d = 1'b1;
            pf_busy_d    = 1'b0;
          end
          // never prefetch beyond the last set of the run
          if (!pf_busy_q && !shadow_vld_q && nxt_ch < och_q) begin
            kick      = 1'b1;
            pf_busy_d = 1'b1;
          end
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef QUAN_BIAS_PREFETCH_EN
        shadow_vld_d = 1'b0;
        pf_busy_d    = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // read issue: low channel on a kick, high channel on the following cycle
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_hi_d   = 1'b0;
    rd_last_d = 1'b0;
    hi_pend_d = 1'b0;
    if (kick) begin
      rd_en_d   = 1'b1;
      rd_addr_d = kick_base + kick_ch[bias_addr_width-1:0];
      rd_last_d = !kick_pair;
      hi_pend_d = kick_pair;
    end else if (hi_pend_q) begin
      rd_en_d   = 1'b1;
      rd_addr_d = rd_addr_q + ADDR_ONE;
      rd_hi_d   = 1'b1;
      rd_last_d = 1'b1;
    end
  end

  // state registers, asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode1_q    <= 1'b0;
      base_q     <= '0;
      och_q      <= '0;
      tps_q      <= '0;
      tile_cnt_q <= '0;
      ch_q       <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_hi_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      hi_pend_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_hi_q   <= 1'b0;
      rsp_last_q <= 1'b0;
      lo_byte_q  <= '0;
      set_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef QUAN_BIAS_PREFETCH_EN
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      pf_busy_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode1_q    <= mode1_d;
      base_q     <= base_d;
      och_q      <= och_d;
      tps_q      <= tps_d;
      tile_cnt_q <= tile_cnt_d;
      ch_q       <= ch_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_hi_q    <= rd_hi_d;
      rd_last_q  <= rd_last_d;
      hi_pend_q  <= hi_pend_d;
      rsp_vld_q  <= rd_en_q;
      rsp_hi_q   <= rd_hi_q;
      rsp_last_q <= rd_last_q;
      lo_byte_q  <= lo_byte_d;
      set_q      <= set_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef QUAN_BIAS_PREFETCH_EN
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      pf_busy_q    <= pf_busy_d;
`endif
    end
  end

  assign bias_rd_en    = rd_en_q;
  assign bias_rd_addr  = rd_addr_q;
  assign next_bias_set = set_q;
  assign bias_valid    = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_quan_bias_set_feeder.sv
// Randomized bench for quan_bias_set_feeder: a behavioural buffer model plus a
// per-run reference built from the channel/set rules (expected reads, sets,
// op sequence, latencies, bubbles).
module tb_quan_bias_set_feeder;

`ifdef QUAN_BIAS_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mode;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  och_num;
  logic [7:0]  tiles_per_set;
  logic        bias_rd_en;
  logic [9:0]  bias_rd_addr;
  logic [7:0]  bias_rd_data;
  logic        vec_en;
  logic [15:0] next_bias_set;
  logic        bias_valid, busy, done;

  logic [7:0]  mem [1024];
  int          n_chk = 0;
  int          n_err = 0;

  quan_bias_set_feeder dut (
    .clk(clk), .reset(rst_n), .mode(mode), .start(start), .base_addr(base_addr),
    .och_num(och_num), .tiles_per_set(tiles_per_set), .bias_rd_en(bias_rd_en),
    .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data), .vec_en(vec_en),
    .next_bias_set(next_bias_set), .bias_valid(bias_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // bias buffer: synchronous read, data one cycle after the strobe
  always @(posedge clk) if (bias_rd_en) bias_rd_data <= mem[bias_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one run; abort_at >= 0 asserts reset once more than abort_at ops consumed
  task automatic run(input int md, input int base, input int och, input int tps,
                     input int vprob, input bit chk_gap, input int abort_at);
    bit          m1;
    int          tpe, step, a, exp_bub, first_v, done_k, last_vec, n_done, gaps, n;
    logic [15:0] s;
    logic [15:0] exp_sets[$];
    logic [15:0] exp_ops[$];
    int          exp_reads[$];
    logic [15:0] got_ops[$];
    int          got_reads[$];
    m1 = (md == 1);
    tpe = (tps == 0) ? 1 : tps;
    step = m1 ? 2 : 1;
    exp_bub = 0; first_v = -1; done_k = -1; last_vec = -1; n_done = 0; gaps = 0;
    for (int c = 0; c < och; c += step) begin
      a = (base + c) % 1024;
      s = {8'h00, mem[a]};
      exp_reads.push_back(a);
      if (m1 && c + 1 < och) begin
        s[15:8] = mem[(a + 1) % 1024];
        exp_reads.push_back((a + 1) % 1024);
        if (c > 0) exp_bub += 3;
      end else if (c > 0) exp_bub += 2;
      exp_sets.push_back(s);
      repeat (tpe) exp_ops.push_back(s);
    end
    if (PF) exp_bub = 0;

    @(negedge clk);
    mode = 4'(md); base_addr = 10'(base); och_num = 10'(och);
    tiles_per_set = 8'(tps); start = 1'b1; vec_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int k = 1; k < BUDGET; k++) begin
      if (k > 1) @(negedge clk);
      if (bias_rd_en) got_reads.push_back(int'(bias_rd_addr));
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (bias_valid && first_v < 0) first_v = k;
      if (chk_gap && first_v >= 0 && !bias_valid && done_k < 0) gaps++;
      vec_en = ($urandom_range(99) < vprob);
      if (vec_en && bias_valid) begin
        got_ops.push_back(next_bias_set);
        last_vec = k;
      end
      if (abort_at >= 0 && got_ops.size() > abort_at) break;
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    vec_en = 1'b0;

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", 32'({next_bias_set, bias_valid, busy, done, bias_rd_en, bias_rd_addr}), 32'd0);
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_ops", 32'(got_ops.size()), 32'(abort_at + 1));
      repeat (2) begin
        @(negedge clk);
        chk("rst_hold_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
    end else begin
      chk("done_cnt", 32'(n_done), 32'd1);
      if (och == 0) chk("done_lat", 32'(done_k), 32'd1);
      else chk("done_after_vec", 32'(done_k), 32'(last_vec + 1));
      chk("first_valid", 32'(first_v), (och == 0) ? 32'hFFFF_FFFF : ((m1 && och > 1) ? 32'd4 : 32'd3));
      chk("busy_end", 32'(busy), 32'd0);
      chk("valid_end", 32'(bias_valid), 32'd0);
      if (och > 0) chk("set_hold", 32'(next_bias_set), 32'(exp_sets[$]));
      chk("n_reads", 32'(got_reads.size()), 32'(exp_reads.size()));
      chk("n_ops", 32'(got_ops.size()), 32'(exp_ops.size()));
      if (chk_gap) chk("bubbles", 32'(gaps), 32'(exp_bub));
    end
    n = (got_reads.size() < exp_reads.size()) ? got_reads.size() : exp_reads.size();
    for (int i = 0; i < n; i++) chk("rd_addr", 32'(got_reads[i]), 32'(exp_reads[i]));
    n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) chk("op_set", 32'(got_ops[i]), 32'(exp_ops[i]));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_en = 1'b0; mode = '0;
    base_addr = '0; och_num = '0; tiles_per_set = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({next_bias_set, bias_valid, busy, done, bias_rd_en, bias_rd_addr}), 32'd0);
    rst_n = 1'b1;

    // mode 0, three channels, two ops each, includes negative and max bytes
    mem[10'h010] = 8'h05; mem[10'h011] = 8'hFB; mem[10'h012] = 8'h7F;
    run(0, 'h010, 3, 2, 100, !PF, -1);
    // mode 1, odd channel count: final set has empty high byte
    for (int i = 0; i < 5; i++) mem[10'h100 + i] = 8'(i + 1);
    run(1, 'h100, 5, 1, 100, !PF, -1);
    // no channels: immediate done, no reads
    run(0, 'h020, 0, 3, 100, 1'b0, -1);
    // address wrap in mode 1
    run(1, 'h3FF, 2, 2, 100, 1'b0, -1);
    // reset during the second set, then a clean restart from channel 0
    run(0, 'h040, 3, 3, 100, 1'b0, 3);
    run(0, 'h040, 3, 3, 100, 1'b0, -1);
    // continuous vec_en, long sets: bubble count per build
    run(0, 'h080, 4, 4, 100, 1'b1, -1);
    // tiles_per_set of 0 behaves as 1, reserved mode behaves as mode 0
    run(7, 'h0C0, 4, 0, 60, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      int md;
      md = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 15));
      run(md, int'($urandom_range(0, 1023)), int'($urandom_range(0, 12)),
          int'($urandom_range(0, 5)), int'($urandom_range(30, 100)), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
